// File: rtl/paint_pkg.sv
// Shared constants, types and cell helpers for the canvas write path.
package paint_pkg;

    localparam int unsigned CANVAS_W     = 48;
    localparam int unsigned CANVAS_H     = 36;
    localparam int unsigned INITIAL_X    = 15;
    localparam int unsigned INITIAL_Y    = 11;
    localparam int unsigned COORD_W      = 6;
    localparam int unsigned OFS_W        = 8;
    localparam int unsigned ADDR_W       = 11;
    localparam int unsigned COLOR_W      = 3;
    localparam int unsigned MOUSE_W      = 7;
    localparam int unsigned CANVAS_CELLS = CANVAS_W * CANVAS_H;

    localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(CANVAS_CELLS - 1);
    localparam logic [1:0]         BRUSH_1X1   = 2'd0;
    localparam logic [1:0]         BRUSH_3X3_A = 2'd1;
    localparam logic [1:0]         BRUSH_3X3_B = 2'd2;
    localparam logic [1:0]         BRUSH_5X5   = 2'd3;
    localparam logic [COLOR_W-1:0] COLOR_EMPTY = 3'b000;

    typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

    function automatic logic [1:0] brush_radius(input logic [1:0] size);
        case (size)
            BRUSH_1X1: return 2'd0;
            BRUSH_5X5: return 2'd2;
            default:   return 2'd1;
        endcase
    endfunction

    function automatic logic signed [OFS_W-1:0] cell_pos(input logic [COORD_W-1:0] base,
                                                         input logic signed [OFS_W-1:0] ofs);
        return signed'(OFS_W'(base)) + ofs;
    endfunction

    // Sign bit rules out negatives before the unsigned upper-bound compare.
    function automatic logic pos_inside(input logic signed [OFS_W-1:0] p, input int unsigned lim);
        return !p[OFS_W-1] && (unsigned'(p) < OFS_W'(lim));
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic signed [OFS_W-1:0] x,
                                                    input logic signed [OFS_W-1:0] y);
        return ADDR_W'(unsigned'(x)) + ADDR_W'(CANVAS_W) * ADDR_W'(unsigned'(y));
    endfunction

endpackage

// File: rtl/brush_offset_counter.sv
// Walks brush offsets dy = -r..r (outer), dx = -r..r (inner); exposes the step-ahead offset.
module brush_offset_counter
    import paint_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic [1:0]              radius,
    output logic signed [OFS_W-1:0] start_c,
    output logic signed [OFS_W-1:0] dx_next_c,
    output logic signed [OFS_W-1:0] dy_next_c,
    output logic                    last_c
);

    logic [1:0]              r_q;
    logic signed [OFS_W-1:0] r_s;
    logic signed [OFS_W-1:0] dx;
    logic signed [OFS_W-1:0] dy;

    assign r_s     = signed'(OFS_W'(r_q));
    assign start_c = -signed'(OFS_W'(radius));
    assign last_c  = (dx == r_s) && (dy == r_s);

    always_comb begin
        dx_next_c = dx + 8'sd1;
        dy_next_c = dy;
        if (dx == r_s) begin
            dx_next_c = -r_s;
            dy_next_c = dy + 8'sd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 2'd0;
            dx  <= '0;
            dy  <= '0;
        end else if (load) begin
            r_q <= radius;
            dx  <= start_c;
            dy  <= start_c;
        end else if (step) begin
            dx  <= dx_next_c;
            dy  <= dy_next_c;
        end
    end

endmodule

// File: rtl/canvas_write_scheduler.sv
// Single-port write sequencer for the canvas store: clipped brush stamps and full clears.
module canvas_write_scheduler
    import paint_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MOUSE_W-1:0]   mouse_x,
    input  logic [MOUSE_W-1:0]   mouse_y,
    input  logic                 mouse_click,
    input  logic                 mode,
    input  logic [COLOR_W-1:0]   color_select,
    input  logic [1:0]           brush_size,
    input  logic                 clear_req,
    output logic                 wr_valid,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [COLOR_W-1:0]   wr_data,
    input  logic                 wr_ready,
    output logic                 busy
);

    state_t state, state_d;
    logic   clear_pend, clear_pend_d;
    logic   last_valid, last_valid_d;
    logic   wr_valid_d, busy_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [COLOR_W-1:0] wr_data_d;
    logic   cap_en, step, rec_en;

    logic [COORD_W-1:0] st_cx, st_cy, last_cx, last_cy;
    logic [COLOR_W-1:0] st_data, last_data;
    logic [1:0]         st_size, last_size;

    logic [COORD_W-1:0] cap_cx, cap_cy;
    logic [COLOR_W-1:0] cap_data;
    logic               in_canvas, is_new;

    logic signed [OFS_W-1:0] start_c, dx_next_c, dy_next_c;
    logic                    last_c;
    logic [COORD_W-1:0]      base_x, base_y;
    logic signed [OFS_W-1:0] ofs_x, ofs_y, px, py;
    logic                    cell_in;
    logic [ADDR_W-1:0]       cell_a;

    assign in_canvas = (mouse_x >= MOUSE_W'(INITIAL_X)) && (mouse_x < MOUSE_W'(INITIAL_X + CANVAS_W)) &&
                       (mouse_y >= MOUSE_W'(INITIAL_Y)) && (mouse_y < MOUSE_W'(INITIAL_Y + CANVAS_H));
    assign cap_cx    = COORD_W'(mouse_x - MOUSE_W'(INITIAL_X));
    assign cap_cy    = COORD_W'(mouse_y - MOUSE_W'(INITIAL_Y));
    assign cap_data  = mode ? COLOR_EMPTY : color_select;
    assign is_new    = !last_valid || (cap_cx != last_cx) || (cap_cy != last_cy) ||
                       (cap_data != last_data) || (brush_size != last_size);

    brush_offset_counter u_ofs (
        .clk       (clk),
        .rst       (rst),
        .load      (cap_en),
        .step      (step),
        .radius    (brush_radius(brush_size)),
        .start_c   (start_c),
        .dx_next_c (dx_next_c),
        .dy_next_c (dy_next_c),
        .last_c    (last_c)
    );

    // Cell about to be presented: the first cell when capturing, otherwise the next offset.
    always_comb begin
        base_x = st_cx;
        base_y = st_cy;
        ofs_x  = dx_next_c;
        ofs_y  = dy_next_c;
        if (state == IDLE) begin
            base_x = cap_cx;
            base_y = cap_cy;
            ofs_x  = start_c;
            ofs_y  = start_c;
        end
        px      = cell_pos(base_x, ofs_x);
        py      = cell_pos(base_y, ofs_y);
        cell_in = pos_inside(px, CANVAS_W) && pos_inside(py, CANVAS_H);
        cell_a  = cell_in ? cell_addr(px, py) : '0;
    end

    always_comb begin
        state_d      = state;
        clear_pend_d = clear_pend;
        last_valid_d = last_valid;
        wr_valid_d   = wr_valid;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        cap_en       = 1'b0;
        step         = 1'b0;
        rec_en       = 1'b0;
        case (state)
            IDLE: begin
                if (clear_pend || clear_req) begin
                    state_d      = CLEAR;
                    clear_pend_d = 1'b0;
                    wr_valid_d   = 1'b1;
                    wr_addr_d    = '0;
                    wr_data_d    = COLOR_EMPTY;
                end else if (mouse_click && in_canvas && is_new) begin
                    state_d    = STAMP;
                    cap_en     = 1'b1;
                    wr_valid_d = cell_in;
                    wr_addr_d  = cell_a;
                    wr_data_d  = cap_data;
                end
            end
            STAMP: begin
                if (clear_req) clear_pend_d = 1'b1;
                // A clipped cell occupies exactly one cycle with wr_valid low.
                if (!wr_valid || wr_ready) begin
                    if (last_c) begin
                        state_d      = IDLE;
                        rec_en       = 1'b1;
                        last_valid_d = 1'b1;
                        wr_valid_d   = 1'b0;
                        wr_addr_d    = '0;
                        wr_data_d    = COLOR_EMPTY;
                    end else begin
                        step       = 1'b1;
                        wr_valid_d = cell_in;
                        wr_addr_d  = cell_a;
                    end
                end
            end
            CLEAR: begin
                if (wr_ready) begin
                    if (wr_addr == LAST_ADDR) begin
                        state_d      = IDLE;
                        last_valid_d = 1'b0;
                        wr_valid_d   = 1'b0;
                        wr_addr_d    = '0;
                    end else begin
                        wr_addr_d = wr_addr + 11'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clear_pend <= 1'b0;
            last_valid <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            st_cx      <= '0;
            st_cy      <= '0;
            st_data    <= '0;
            st_size    <= '0;
            last_cx    <= '0;
            last_cy    <= '0;
            last_data  <= '0;
            last_size  <= '0;
        end else begin
            state      <= state_d;
            clear_pend <= clear_pend_d;
            last_valid <= last_valid_d;
            wr_valid   <= wr_valid_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            busy       <= busy_d;
            if (cap_en) begin
                st_cx   <= cap_cx;
                st_cy   <= cap_cy;
                st_data <= cap_data;
                st_size <= brush_size;
            end
            if (rec_en) begin
                last_cx   <= st_cx;
                last_cy   <= st_cy;
                last_data <= st_data;
                last_size <= st_size;
            end
        end
    end

endmodule

// File: tb/tb_canvas_write_scheduler.sv
// Scoreboard bench for canvas_write_scheduler: expected writes queued at stimulus, popped on handshake.
module tb_canvas_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  mouse_x, mouse_y;
    logic        mouse_click, mode, clear_req, wr_ready;
    logic [2:0]  color_select;
    logic [1:0]  brush_size;
    logic        wr_valid, busy;
    logic [10:0] wr_addr;
    logic [2:0]  wr_data;

    int checks = 0;
    int errors = 0;
    int n_hs = 0;
    int busy_cyc = 0;
    int clip_cyc = 0;
    int stall_n = 0;
    logic [13:0] exp_q[$];

    bit          s_valid, s_busy;
    logic [10:0] s_addr;
    bit          p_valid, p_ready, p_rst, clear_end_chk, toggle_ready;
    logic [10:0] p_addr;
    logic [2:0]  p_data;

    always #5 clk = ~clk;

    canvas_write_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_click  (mouse_click),
        .mode         (mode),
        .color_select (color_select),
        .brush_size   (brush_size),
        .clear_req    (clear_req),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .busy         (busy)
    );

    // Reference stamp: canvas coordinate, radius and clipping straight from the screen position.
    task automatic push_stamp(input int mx, input int my, input int size, input bit erase, input int col);
        int cx, cy, r;
        logic [2:0] d;
        cx = mx - 15;
        cy = my - 11;
        r  = (size == 0) ? 0 : (size == 3) ? 2 : 1;
        d  = erase ? 3'b000 : 3'(col);
        for (int dy = -r; dy <= r; dy++)
            for (int dx = -r; dx <= r; dx++)
                if (cx + dx >= 0 && cx + dx < 48 && cy + dy >= 0 && cy + dy < 36)
                    exp_q.push_back({11'((cx + dx) + 48 * (cy + dy)), d});
    endtask

    task automatic push_clear(input int last);
        for (int i = 0; i <= last; i++) exp_q.push_back({11'(i), 3'b000});
    endtask

    task automatic tick();
        logic [13:0] e;
        @(negedge clk);
        s_valid = wr_valid;
        s_busy  = busy;
        s_addr  = wr_addr;
        if (clear_end_chk) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL clear_busy_fall: busy=%b after final clear write, want 0", busy);
            end
            clear_end_chk = 0;
        end
        if (p_valid && !p_ready && !p_rst && !rst) begin
            stall_n++;
            checks++;
            if (wr_valid !== 1'b1 || wr_addr !== p_addr || wr_data !== p_data) begin
                errors++;
                $display("FAIL stall_hold: valid=%b addr=%0d data=%b, want 1 %0d %b",
                         wr_valid, wr_addr, wr_data, p_addr, p_data);
            end
        end
        if (busy === 1'b1) busy_cyc++;
        if (busy === 1'b1 && wr_valid === 1'b0) clip_cyc++;
        if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
            n_hs++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%b, want no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write: addr=%0d data=%b, want addr=%0d data=%b",
                             wr_addr, wr_data, e[13:3], e[2:0]);
                end
            end
            if (wr_addr == 11'd1727) clear_end_chk = 1;
        end
        p_valid = wr_valid;
        p_ready = wr_ready;
        p_rst   = rst;
        p_addr  = wr_addr;
        p_data  = wr_data;
        @(posedge clk);
        #1;
        if (toggle_ready) wr_ready = ~wr_ready;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        busy_cyc = 0;
        clip_cyc = 0;
        do begin
            tick();
            n++;
        end while ((exp_q.size() != 0 || s_busy) && n < maxc);
        checks++;
        if (exp_q.size() != 0 || s_busy) begin
            errors++;
            $display("FAIL drain_timeout: %0d writes pending, busy=%b, want 0 and 0", exp_q.size(), s_busy);
            exp_q.delete();
        end
    endtask

    task automatic click(input int mx, input int my, input int size, input bit erase, input int col);
        mouse_x      = 7'(mx);
        mouse_y      = 7'(my);
        brush_size   = 2'(size);
        mode         = erase;
        color_select = 3'(col);
        mouse_click  = 1'b1;
        push_stamp(mx, my, size, erase, col);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mouse_x = '0; mouse_y = '0; mouse_click = 1'b0; mode = 1'b0;
        color_select = '0; brush_size = '0; clear_req = 1'b0; wr_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({wr_valid, busy, wr_addr, wr_data} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b busy=%b addr=%0d data=%b, want all 0",
                     wr_valid, busy, wr_addr, wr_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_and_hold();
        int hs0;
        click(34, 26, 0, 1'b0, 3'b100);
        tick();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_capture: wr_valid=%b in capture cycle, want 0", s_valid);
        end
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_addr !== 11'd739) begin
            errors++;
            $display("FAIL latency_first: valid=%b addr=%0d, want 1 739", s_valid, s_addr);
        end
        wait_drain(20);
        hs0 = n_hs;
        repeat (20) tick();
        checks++;
        if (n_hs != hs0 || s_busy) begin
            errors++;
            $display("FAIL held_click: %0d extra writes busy=%b, want 0 and 0", n_hs - hs0, s_busy);
        end
        mouse_click = 1'b0;
        tick();
    endtask

    task automatic test_corner_clip();
        int hs0;
        hs0 = n_hs;
        click(15, 11, 3, 1'b0, 3'b001);
        wait_drain(60);
        checks++;
        if (n_hs - hs0 != 9 || busy_cyc != 25 || clip_cyc != 16) begin
            errors++;
            $display("FAIL corner_5x5: writes=%0d busy=%0d clipped=%0d, want 9 25 16",
                     n_hs - hs0, busy_cyc, clip_cyc);
        end
        mouse_click = 1'b0;
        tick();
    endtask

    task automatic test_edge_erase();
        int hs0;
        hs0 = n_hs;
        click(62, 21, 1, 1'b1, 3'b111);
        wait_drain(40);
        checks++;
        if (n_hs - hs0 != 6) begin
            errors++;
            $display("FAIL edge_erase_count: writes=%0d, want 6", n_hs - hs0);
        end
        mouse_click = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        int hs0, st0;
        hs0 = n_hs;
        st0 = stall_n;
        wr_ready = 1'b0;
        toggle_ready = 1'b1;
        click(25, 21, 2, 1'b0, 3'b011);
        wait_drain(80);
        toggle_ready = 1'b0;
        wr_ready = 1'b1;
        checks++;
        if (n_hs - hs0 != 9 || stall_n - st0 < 4) begin
            errors++;
            $display("FAIL stall_stamp: writes=%0d stalls=%0d, want 9 and at least 4",
                     n_hs - hs0, stall_n - st0);
        end
        mouse_click = 1'b0;
        tick();
    endtask

    task automatic test_clear_during_stamp();
        int hs0;
        hs0 = n_hs;
        click(35, 31, 3, 1'b0, 3'b010);
        push_clear(1727);
        push_stamp(35, 31, 3, 1'b0, 3'b010);
        tick();
        tick();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_drain(4000);
        checks++;
        if (n_hs - hs0 != 25 + 1728 + 25) begin
            errors++;
            $display("FAIL clear_sequence: writes=%0d, want 1778", n_hs - hs0);
        end
        hs0 = n_hs;
        repeat (10) tick();
        checks++;
        if (n_hs != hs0) begin
            errors++;
            $display("FAIL restamp_once: %0d extra writes, want 0", n_hs - hs0);
        end
        mouse_click = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int n, hs0;
        clear_req = 1'b1;
        push_clear(499);
        tick();
        clear_req = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 700) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL clear_timeout: %0d writes pending, want 0", exp_q.size());
            exp_q.delete();
        end
        rst = 1'b1;
        wr_ready = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_addr !== 11'd500) begin
            errors++;
            $display("FAIL clear_at_500: valid=%b addr=%0d, want 1 500", s_valid, s_addr);
        end
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: valid=%b busy=%b, want 0 0", s_valid, s_busy);
        end
        rst = 1'b0;
        wr_ready = 1'b1;
        hs0 = n_hs;
        repeat (20) tick();
        checks++;
        if (n_hs != hs0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_resume: %0d writes busy=%b, want 0 0", n_hs - hs0, s_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_and_hold();
        test_corner_clip();
        test_edge_erase();
        test_stall();
        test_clear_during_stamp();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
